fetch_unit_32: RTL and testbench

FETCH_UNIT_32 -- requirements
Module: fetch_unit_32

---
 rtl/fetch_unit_32.sv | 182 ++++++++++++++++++
 tb/tb_fetch_unit_32.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_32.sv
// rtl/fetch_unit_32.sv - instruction fetch unit with PC sequencing, jump/branch resolution and hold register
//
// Purpose:
//   Fetches one 32-bit word at a time from instruction memory, holds it for
//   the downstream stage until it is consumed, and then computes the next PC.
//   The next PC is chosen in this order: jump (j/jal/jr), then a taken
//   beq/bne, then sequential.
//
// Optional feature:
//   FETCH_ICOUNT_EN - when defined, instr_count counts consumed instructions.
//                     When undefined, instr_count is tied to zero and no
//                     counter register exists.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   imem_req       out  1   fetch request, held until imem_ack
//   imem_addr      out  32  fetch address (current PC)
//   imem_ack       in   1   memory acknowledge, imem_rdata valid same cycle
//   imem_rdata     in   32  fetched instruction word
//   stall          in   1   downstream not ready, hold current instruction
//   jump           in   2   00 none, 01 j, 10 jal, 11 jr
//   branch         in   2   00 none, 01 beq, 10 bne, 11 none
//   zero           in   1   ALU equality flag for the held instruction
//   jr_target      in   32  rs value used as jr target
//   instr          out  32  held instruction
//   opcode         out  6   instr[31:26]
//   instr_valid    out  1   instr/opcode valid
//   pc_plus4       out  32  held instruction address + 4 (link value)
//   err_misaligned out  1   sticky: jr target had nonzero low bits
//   instr_count    out  32  consumed-instruction counter

module fetch_unit_32 #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic [1:0]  jump,
   input  logic [1:0]  branch,
   input  logic        zero,
   input  logic [31:0] jr_target,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   output logic [31:0] pc_plus4,
   output logic        err_misaligned,
   output logic [31:0] instr_count
);

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        err_q, err_d;
   logic        consume;

   // Target candidates, all derived from the held instruction and its link value
   logic [31:0] j_target;
   logic [31:0] jr_aligned;
   logic [31:0] br_offset;
   logic [31:0] br_target;
   logic        br_taken;
   logic [31:0] next_pc;

   assign j_target   = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
   assign jr_aligned = {jr_target[31:2], 2'b00};
   assign br_offset  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   // 32-bit add wraps naturally modulo 2^32
   assign br_target  = pc_plus4_q + br_offset;

   always_comb begin
      br_taken = 1'b0;
      case (branch)
         2'b01:   br_taken = zero;
         2'b10:   br_taken = ~zero;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      next_pc = pc_plus4_q;
      case (jump)
         2'b01, 2'b10: next_pc = j_target;
         2'b11:        next_pc = jr_aligned;
         default: begin
            if (br_taken) begin
               next_pc = br_target;
            end
         end
      endcase
   end

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      err_d      = err_q;
      consume    = 1'b0;
      case (state_q)
         FETCH: begin
            // stall is deliberately ignored here
            if (imem_ack) begin
               instr_d    = imem_rdata;
               pc_plus4_d = pc_q + 32'd4;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            // imem_ack is ignored here; control inputs matter only when consuming
            if (!stall) begin
               consume = 1'b1;
               pc_d    = next_pc;
               state_d = FETCH;
               if ((jump == 2'b11) && (jr_target[1:0] != 2'b00)) begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         instr_q    <= 32'h0;
         pc_plus4_q <= 32'h0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         err_q      <= err_d;
      end
   end

`ifdef FETCH_ICOUNT_EN
   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (consume) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 32'h0;
      end else begin
         count_q <= count_d;
      end
   end

   assign instr_count = count_q;
`else
   assign instr_count = 32'h0;
`endif

   assign imem_req       = (state_q == FETCH);
   assign imem_addr      = pc_q;
   assign instr          = instr_q;
   assign opcode         = instr_q[31:26];
   assign instr_valid    = (state_q == HOLD);
   assign pc_plus4       = pc_plus4_q;
   assign err_misaligned = err_q;

endmodule

// File: tb/tb_fetch_unit_32.sv
// tb/tb_fetch_unit_32.sv - self-checking testbench for fetch_unit_32

module tb_fetch_unit_32;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic [1:0]  jump;
   logic [1:0]  branch;
   logic        zero;
   logic [31:0] jr_target;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic [31:0] pc_plus4;
   logic        err_misaligned;
   logic [31:0] instr_count;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   fetch_unit_32 #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .jump           (jump),
      .branch         (branch),
      .zero           (zero),
      .jr_target      (jr_target),
      .instr          (instr),
      .opcode         (opcode),
      .instr_valid    (instr_valid),
      .pc_plus4       (pc_plus4),
      .err_misaligned (err_misaligned),
      .instr_count    (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference state
   logic [31:0] ref_pc;
   logic [31:0] ref_p4;
   logic        ref_err;
   logic [31:0] ref_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_count();
`ifdef FETCH_ICOUNT_EN
      return ref_cnt;
`else
      return 32'h0;
`endif
   endfunction

   // Next PC from the architectural rules, using plain integer arithmetic
   function automatic logic [31:0] model_next(input logic [31:0] pc4, input logic [31:0] word,
                                              input logic [1:0] j, input logic [1:0] b,
                                              input logic z, input logic [31:0] jrt);
      int imm;
      imm = int'($signed(word[15:0]));
      if (j == 2'd1 || j == 2'd2) return (pc4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
      if (j == 2'd3) return jrt & 32'hFFFF_FFFC;
      if ((b == 2'd1 && z) || (b == 2'd2 && !z)) return pc4 + 32'(imm * 4);
      return pc4;
   endfunction

   task automatic junk_ctrl();
      jump      = 2'($urandom);
      branch    = 2'($urandom);
      zero      = 1'($urandom);
      jr_target = $urandom;
   endtask

   // One full fetch/hold/consume transaction, starting and ending at a negedge in FETCH
   task automatic do_instr(input logic [31:0] word, input int waits, input int stalls,
                           input logic [1:0] j, input logic [1:0] b, input logic z,
                           input logic [31:0] jrt);
      logic [31:0] exp_next;
      chk("fetch_req", {31'b0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, ref_pc);
      chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
      for (int w = 0; w < waits; w++) begin
         imem_ack = 1'b0;
         stall    = 1'($urandom);
         junk_ctrl();
         @(negedge clk);
         chk("wait_addr", imem_addr, ref_pc);
         chk("wait_req", {31'b0, imem_req}, 32'd1);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      stall      = 1'($urandom);
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      ref_p4 = ref_pc + 32'd4;
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_instr", instr, word);
      chk("hold_opcode", {26'b0, opcode}, {26'b0, word[31:26]});
      chk("hold_pc4", pc_plus4, ref_p4);
      for (int s = 0; s < stalls; s++) begin
         stall      = 1'b1;
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         junk_ctrl();
         @(negedge clk);
         chk("stall_instr", instr, word);
         chk("stall_opcode", {26'b0, opcode}, {26'b0, word[31:26]});
         chk("stall_req", {31'b0, imem_req}, 32'd0);
         chk("stall_pc4", pc_plus4, ref_p4);
         chk("stall_count", instr_count, exp_count());
      end
      imem_ack  = 1'b0;
      stall     = 1'b0;
      jump      = j;
      branch    = b;
      zero      = z;
      jr_target = jrt;
      exp_next  = model_next(ref_p4, word, j, b, z, jrt);
      @(negedge clk);
      ref_pc  = exp_next;
      ref_cnt = ref_cnt + 32'd1;
      if (j == 2'd3 && jrt[1:0] != 2'b00) ref_err = 1'b1;
      junk_ctrl();
      stall = 1'($urandom);
      chk("next_addr", imem_addr, ref_pc);
      chk("err_flag", {31'b0, err_misaligned}, {31'b0, ref_err});
      chk("count", instr_count, exp_count());
   endtask

   task automatic reset_checks();
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_pc4", pc_plus4, 32'h0);
      chk("rst_err", {31'b0, err_misaligned}, 32'd0);
      chk("rst_count", instr_count, 32'h0);
      chk("rst_addr", imem_addr, RST_PC);
   endtask

   initial begin
      logic [31:0] w;
      rst_n      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      stall      = 1'b0;
      jump       = 2'd0;
      branch     = 2'd0;
      zero       = 1'b0;
      jr_target  = 32'h0;
      ref_pc  = RST_PC;
      ref_p4  = 32'h0;
      ref_err = 1'b0;
      ref_cnt = 32'h0;
      #1;
      reset_checks();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // lw after two wait cycles, then sequential
      do_instr(32'h8C01_0004, 2, 0, 2'd0, 2'd0, 1'b0, 32'h0);
      chk("lw_next", imem_addr, 32'h0000_0004);

      // beq / bne around PC 0x10 with imm -4
      do_instr(32'h0800_0004, 0, 1, 2'd1, 2'd0, 1'b0, 32'h0);
      chk("j_to_10", imem_addr, 32'h0000_0010);
      do_instr(32'h10A5_FFFC, 1, 0, 2'd0, 2'd1, 1'b1, 32'h0);
      chk("beq_taken", imem_addr, 32'h0000_0004);
      do_instr(32'h0800_0004, 0, 0, 2'd1, 2'd0, 1'b0, 32'h0);
      do_instr(32'h10A5_FFFC, 0, 0, 2'd0, 2'd1, 1'b0, 32'h0);
      chk("beq_not_taken", imem_addr, 32'h0000_0014);
      do_instr(32'h0800_0004, 0, 0, 2'd1, 2'd0, 1'b0, 32'h0);
      do_instr(32'h14A5_FFFC, 0, 0, 2'd0, 2'd2, 1'b0, 32'h0);
      chk("bne_taken", imem_addr, 32'h0000_0004);

      // j / jal at 0x1000_0020; jal held under a 5-cycle stall
      do_instr(32'h0000_0008, 0, 0, 2'd3, 2'd0, 1'b0, 32'h1000_0020);
      chk("jr_to_1000_0020", imem_addr, 32'h1000_0020);
      do_instr(32'h0800_0040, 0, 0, 2'd1, 2'd1, 1'b1, 32'h0);
      chk("j_target", imem_addr, 32'h1000_0100);
      do_instr(32'h0000_0008, 0, 0, 2'd3, 2'd0, 1'b0, 32'h1000_0020);
      do_instr(32'h0C00_0040, 1, 5, 2'd2, 2'd2, 1'b0, 32'h0);
      chk("jal_target", imem_addr, 32'h1000_0100);

      // Wrap at the top of the address space
      do_instr(32'h0000_0008, 0, 0, 2'd3, 2'd0, 1'b0, 32'hFFFF_FFFC);
      do_instr(32'h10A5_0000, 0, 0, 2'd0, 2'd1, 1'b1, 32'h0);
      chk("wrap_branch", imem_addr, 32'h0000_0000);

      // Reset while a request is outstanding at 0x40
      do_instr(32'h0000_0008, 0, 0, 2'd3, 2'd0, 1'b0, 32'h0000_0040);
      chk("pre_rst_addr", imem_addr, 32'h0000_0040);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      reset_checks();
      @(negedge clk);
      rst_n = 1'b1;
      ref_pc  = RST_PC;
      ref_p4  = 32'h0;
      ref_err = 1'b0;
      ref_cnt = 32'h0;
      chk("post_rst_addr", imem_addr, RST_PC);
      chk("post_rst_req", {31'b0, imem_req}, 32'd1);

      // Misaligned jr sets the sticky flag
      do_instr(32'h0000_0008, 0, 0, 2'd3, 2'd0, 1'b0, 32'h0000_0203);
      chk("jr_misaligned_addr", imem_addr, 32'h0000_0200);
      chk("jr_misaligned_err", {31'b0, err_misaligned}, 32'd1);

      // Randomized transactions against the reference model
      for (int i = 0; i < 40; i++) begin
         w = $urandom;
         do_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  2'($urandom), 2'($urandom), 1'($urandom), $urandom);
      end
      chk("err_sticky_end", {31'b0, err_misaligned}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
